// File: rtl/motor_relu_rx_pkg.sv
// Shared widths and the ReLU-to-fixed conversion for the motor ReLU vector receiver.
package motor_relu_rx_pkg;

    localparam int ELEM_W = 15;  // ReLU magnitude bits
    localparam int FIX_W  = 16;  // ap_fixed<16,7>
    localparam int FIX_I  = 7;   // integer bits, binary point unchanged by conversion

    typedef logic [FIX_W-1:0] fix16_t;

    // ReLU output is already non-negative, so re-expansion is a plain zero-extend.
    function automatic fix16_t relu_to_fix(input logic [ELEM_W-1:0] r);
        return {1'b0, r};
    endfunction

endpackage

// File: rtl/motor_relu_rx_bank.sv
// One ping-pong vector bank: element register file, full flag and optional zero counter.
// Optional zero counter enabled by MOTOR_RELU_RX_ZCNT_EN.
module motor_relu_rx_bank #(
    parameter int N_ELEM = 8,
    parameter int FIX_W  = 16,
    parameter int IDX_W  = $clog2(N_ELEM),
    parameter int ZC_W   = $clog2(N_ELEM + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [IDX_W-1:0]          widx,
    input  logic [FIX_W-1:0]          wdata,
    input  logic                      set_full,
    input  logic                      clr_full,
`ifdef MOTOR_RELU_RX_ZCNT_EN
    input  logic                      wzero,
    input  logic                      zclr,
    output logic [ZC_W-1:0]           zcnt,
`endif
    output logic [N_ELEM*FIX_W-1:0]   data,
    output logic                      full
);

    logic [N_ELEM-1:0][FIX_W-1:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem  <= '0;
            full <= 1'b0;
        end else begin
            if (we)
                mem[widx] <= wdata;
            if (set_full)
                full <= 1'b1;
            else if (clr_full)
                full <= 1'b0;
        end
    end

    assign data = mem;

`ifdef MOTOR_RELU_RX_ZCNT_EN
    // Restart on the first element of a fill so stale counts never leak into a new vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            zcnt <= '0;
        else if (zclr)
            zcnt <= '0;
        else if (we)
            zcnt <= ((widx == '0) ? '0 : zcnt) + ZC_W'(wzero);
    end
`endif

endmodule

// File: rtl/motor_relu_vec_rx.sv
// ReLU stream to layer-input vector receiver with ping-pong double buffering.
// Optional activation zero counter enabled by MOTOR_RELU_RX_ZCNT_EN.
module motor_relu_vec_rx #(
    parameter int N_ELEM = 8,
    parameter int ELEM_W = 15,
    parameter int FIX_W  = 16
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        flush,
    input  logic [ELEM_W-1:0]           s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [N_ELEM*FIX_W-1:0]     v_data,
    output logic                        v_valid,
`ifdef MOTOR_RELU_RX_ZCNT_EN
    output logic [$clog2(N_ELEM+1)-1:0] v_zcnt,
`endif
    input  logic                        v_ready
);

    localparam int IDX_W = $clog2(N_ELEM);
    localparam int ZC_W  = $clog2(N_ELEM + 1);

    logic                                wr_bank, rd_bank;
    logic [IDX_W-1:0]                    idx;
    logic [1:0]                          full;
    logic [1:0][N_ELEM*FIX_W-1:0]        bank_data;
    logic [FIX_W-1:0]                    elem;
    logic                                accept, last, consume;

    assign elem    = FIX_W'(motor_relu_rx_pkg::relu_to_fix(s_data));
    assign s_ready = !full[wr_bank];
    // flush takes priority: an element offered alongside it is dropped.
    assign accept  = s_valid && s_ready && !flush;
    assign last    = accept && (idx == IDX_W'(N_ELEM - 1));
    assign v_valid = full[rd_bank];
    assign v_data  = bank_data[rd_bank];
    assign consume = v_valid && v_ready;

`ifdef MOTOR_RELU_RX_ZCNT_EN
    logic [1:0][ZC_W-1:0] zc;
    assign v_zcnt = zc[rd_bank];
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        motor_relu_rx_bank #(
            .N_ELEM (N_ELEM),
            .FIX_W  (FIX_W),
            .IDX_W  (IDX_W),
            .ZC_W   (ZC_W)
        ) u_bank (
            .clk      (ap_clk),
            .rst_n    (ap_rst_n),
            .we       (accept && (wr_bank == 1'(b))),
            .widx     (idx),
            .wdata    (elem),
            .set_full (last && (wr_bank == 1'(b))),
            .clr_full (consume && (rd_bank == 1'(b))),
`ifdef MOTOR_RELU_RX_ZCNT_EN
            .wzero    (s_data == '0),
            .zclr     (flush && (wr_bank == 1'(b)) && !full[b]),
            .zcnt     (zc[b]),
`endif
            .data     (bank_data[b]),
            .full     (full[b])
        );
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            idx     <= '0;
        end else begin
            if (flush)
                idx <= '0;
            else if (accept) begin
                if (last) begin
                    idx     <= '0;
                    wr_bank <= ~wr_bank;
                end else
                    idx <= idx + 1'b1;
            end
            if (consume)
                rd_bank <= ~rd_bank;
        end
    end

endmodule
